// File: rtl/logisim_clk_pkg.sv
// rtl/logisim_clk_pkg.sv - shared encodings for the multi-channel Logisim clock generator
// Contents: run-mode encodings, clock-bus bit indices and width, step FSM and channel
// phase enums, and the tick-enable decode shared by the top level.
package logisim_clk_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int CB_CLK   = 0;
    localparam int CB_CLK_N = 1;
    localparam int CB_RISE  = 2;
    localparam int CB_FALL  = 3;
    localparam int CB_GCLK  = 4;
    localparam int CB_WIDTH = 5;

    typedef enum logic {
        STEP_IDLE = 1'b0,
        STEP_BUSY = 1'b1
    } step_state_t;

    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } phase_t;

    // Encoding 11 is unassigned and behaves as run; halt is the only mode that
    // never ticks, step ticks only while a step is in flight.
    function automatic logic ticking_enabled(input logic [1:0] mode, input logic busy);
        return (mode == MODE_RUN) || (mode == 2'b11) || ((mode == MODE_STEP) && busy);
    endfunction

endpackage

// File: rtl/logisim_clock_channel.sv
// rtl/logisim_clock_channel.sv - one derived clock channel driven by the shared tick
// Ports:
//   clk    in  : FPGA clock, also passed through on bus[CB_GCLK]
//   rst_n  in  : asynchronous active-low reset
//   tick   in  : one-cycle tick strobe from the divider
//   bus    out : {gclk, fall, rise, clk_n, clk} Logisim clock-tree bus
module logisim_clock_channel
    import logisim_clk_pkg::*;
#(
    parameter logic [7:0] HighTicks = 8'd1,
    parameter logic [7:0] LowTicks  = 8'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    output logic [CB_WIDTH-1:0] bus
);

    phase_t     phase;
    logic [7:0] remaining;
    logic       clk_q;
    logic       clk_n_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PHASE_LOW;
            remaining <= LowTicks;
            clk_q     <= 1'b0;
            clk_n_q   <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
                // <= 1 rather than == 1 so a zero phase length cannot stall the channel.
                if (remaining <= 8'd1) begin
                    if (phase == PHASE_LOW) begin
                        phase     <= PHASE_HIGH;
                        remaining <= HighTicks;
                        clk_q     <= 1'b1;
                        clk_n_q   <= 1'b0;
                        rise_q    <= 1'b1;
                    end else begin
                        phase     <= PHASE_LOW;
                        remaining <= LowTicks;
                        clk_q     <= 1'b0;
                        clk_n_q   <= 1'b1;
                        fall_q    <= 1'b1;
                    end
                end else begin
                    remaining <= remaining - 8'd1;
                end
            end
        end
    end

    assign bus[CB_CLK]   = clk_q;
    assign bus[CB_CLK_N] = clk_n_q;
    assign bus[CB_RISE]  = rise_q;
    assign bus[CB_FALL]  = fall_q;
    assign bus[CB_GCLK]  = clk;

endmodule

// File: rtl/logisim_multi_clock_gen.sv
// rtl/logisim_multi_clock_gen.sv - programmable tick divider feeding N Logisim clock channels
// Ports:
//   FPGA_GlobalClock   in  : single FPGA clock
//   FPGA_GlobalReset_n in  : asynchronous active-low reset
//   Mode               in  : 00 run, 01 halt, 10 step, 11 run
//   Step               in  : single-step request (step mode only)
//   ReloadWe/ReloadData in : runtime tick-period write
//   ClockBus           out : 5 bits per channel, see logisim_clock_channel
//   Tick               out : one-cycle divider strobe
//   Busy               out : high while a single step is in progress
module logisim_multi_clock_gen
    import logisim_clk_pkg::*;
#(
    parameter int                        NrOfChannels = 2,
    parameter int                        NrOfBits     = 32,
    parameter int                        ReloadValue  = 3125000,
    parameter logic [NrOfChannels*8-1:0] HighTicksVec = {NrOfChannels{8'd1}},
    parameter logic [NrOfChannels*8-1:0] LowTicksVec  = {NrOfChannels{8'd1}}
) (
    input  logic                             FPGA_GlobalClock,
    input  logic                             FPGA_GlobalReset_n,
    input  logic [1:0]                       Mode,
    input  logic                             Step,
    input  logic                             ReloadWe,
    input  logic [NrOfBits-1:0]              ReloadData,
    output logic [CB_WIDTH*NrOfChannels-1:0] ClockBus,
    output logic                             Tick,
    output logic                             Busy
);

    localparam logic [NrOfBits-1:0] ONE         = NrOfBits'(1);
    localparam logic [NrOfBits-1:0] RELOAD_INIT = NrOfBits'(ReloadValue);
    // Periods 0 and 1 both mean "tick every cycle", so both load a zero count.
    localparam logic [NrOfBits-1:0] COUNT_INIT  = (RELOAD_INIT <= ONE) ? '0 : RELOAD_INIT - ONE;

    logic [NrOfBits-1:0] reload_reg;
    logic [NrOfBits-1:0] count;
    logic                tick_q;
    logic                tick_en;
    logic                ch0_fall;
    step_state_t         state;
    step_state_t         state_next;

    assign tick_en  = ticking_enabled(Mode, Busy);
    assign ch0_fall = ClockBus[CB_FALL];
    assign Tick     = tick_q;

    // The reload register and the divider share an edge: a write landing on
    // the reload edge is not yet visible, so that reload uses the old period.
    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            reload_reg <= RELOAD_INIT;
            count      <= COUNT_INIT;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (ReloadWe) begin
                reload_reg <= ReloadData;
            end
            if (tick_en) begin
                if (count == '0) begin
                    tick_q <= 1'b1;
                    count  <= (reload_reg <= ONE) ? '0 : reload_reg - ONE;
                end else begin
                    count <= count - ONE;
                end
            end
        end
    end

    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            state <= STEP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A step spans one full channel-0 period: it ends on channel 0's falling strobe.
    always_comb begin
        state_next = state;
        case (state)
            STEP_IDLE: begin
                if ((Mode == MODE_STEP) && Step) begin
                    state_next = STEP_BUSY;
                end
            end
            STEP_BUSY: begin
                if ((Mode != MODE_STEP) || ch0_fall) begin
                    state_next = STEP_IDLE;
                end
            end
            default: state_next = STEP_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == STEP_BUSY);
    end

    for (genvar k = 0; k < NrOfChannels; k++) begin : g_ch
        logisim_clock_channel #(
            .HighTicks (HighTicksVec[8*k +: 8]),
            .LowTicks  (LowTicksVec[8*k +: 8])
        ) u_channel (
            .clk   (FPGA_GlobalClock),
            .rst_n (FPGA_GlobalReset_n),
            .tick  (tick_q),
            .bus   (ClockBus[CB_WIDTH*k +: CB_WIDTH])
        );
    end

endmodule

// File: tb/tb_logisim_multi_clock_gen.sv
// tb/tb_logisim_multi_clock_gen.sv - scoreboard bench for logisim_multi_clock_gen
module tb_logisim_multi_clock_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        step;
    logic        we;
    logic [15:0] data;
    logic [9:0]  bus;
    logic        tick;
    logic        busy;

    int cyc = 0;
    int c0 = 0;
    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    bit mon_en = 1'b0;
    bit mon_ch1 = 1'b0;
    logic prev_clk0 = 1'b0;
    logic prev_busy = 1'b0;

    int q_tick[$];
    int q_r0[$];
    int q_f0[$];
    int q_r1[$];
    int q_f1[$];
    int q_busy[$];

    logisim_multi_clock_gen #(
        .NrOfChannels (2),
        .NrOfBits     (16),
        .ReloadValue  (4),
        .HighTicksVec (16'h0201),
        .LowTicksVec  (16'h0301)
    ) dut (
        .FPGA_GlobalClock   (clk),
        .FPGA_GlobalReset_n (rst_n),
        .Mode               (mode),
        .Step               (step),
        .ReloadWe           (we),
        .ReloadData         (data),
        .ClockBus           (bus),
        .Tick               (tick),
        .Busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_eq(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic sb_pop(input int k, input string nm);
        int  exp_c;
        bit  have;
        have  = 1'b0;
        exp_c = 0;
        case (k)
            0: if (q_tick.size() != 0) begin exp_c = q_tick.pop_front(); have = 1'b1; end
            1: if (q_r0.size() != 0)   begin exp_c = q_r0.pop_front();   have = 1'b1; end
            2: if (q_f0.size() != 0)   begin exp_c = q_f0.pop_front();   have = 1'b1; end
            3: if (q_r1.size() != 0)   begin exp_c = q_r1.pop_front();   have = 1'b1; end
            4: if (q_f1.size() != 0)   begin exp_c = q_f1.pop_front();   have = 1'b1; end
            default: if (q_busy.size() != 0) begin exp_c = q_busy.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s: event at cycle %0d, none required", nm, cyc - c0);
        end else if (exp_c != cyc) begin
            errors++;
            $display("FAIL %s: event at cycle %0d, required at cycle %0d", nm, cyc - c0, exp_c - c0);
        end
    endtask

    task automatic sb_drained(input string nm);
        expect_eq(nm, q_tick.size() + q_r0.size() + q_f0.size() + q_r1.size()
                      + q_f1.size() + q_busy.size(), 0);
    endtask

    task automatic sb_flush();
        q_tick.delete();
        q_r0.delete();
        q_f0.delete();
        q_r1.delete();
        q_f1.delete();
        q_busy.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        sb_flush();
        go_to(cyc + 2);
        rst_n  = 1'b1;
        c0     = cyc;
        mon_en = 1'b1;
    endtask

    // Monitor: every strobe or Busy edge the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tick) sb_pop(0, "tick");
            if (bus[2]) begin
                sb_pop(1, "ch0 rise");
                expect_eq("ch0 rise levels {prev,clk,clk_n}", {prev_clk0, bus[0], bus[1]}, 3'b010);
            end
            if (bus[3]) begin
                sb_pop(2, "ch0 fall");
                expect_eq("ch0 fall levels {prev,clk,clk_n}", {prev_clk0, bus[0], bus[1]}, 3'b101);
            end
            if (mon_ch1 && bus[7]) sb_pop(3, "ch1 rise");
            if (mon_ch1 && bus[8]) sb_pop(4, "ch1 fall");
            if (busy != prev_busy) sb_pop(5, "busy edge");
        end
        if (tick) tick_seen++;
        prev_clk0 = bus[0];
        prev_busy = busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] snap;
        int         mism;
        int         t0;

        rst_n = 1'b0;
        mode  = 2'b00;
        step  = 1'b0;
        we    = 1'b0;
        data  = '0;

        // Reset values
        go_to(3);
        expect_eq("reset levels {ch1[3:0],ch0[3:0]}", {bus[8:5], bus[3:0]}, 8'h22);
        expect_eq("reset tick", tick, 0);
        expect_eq("reset busy", busy, 0);
        expect_eq("gclk passthrough high", {bus[9], bus[4]}, 2'b11);
        @(negedge clk);
        #1;
        expect_eq("gclk passthrough low", {bus[9], bus[4]}, 2'b00);

        // Run at reload 4, H=L=1, then runtime reloads to 8 and back to 4
        go_to(5);
        rst_n  = 1'b1;
        c0     = cyc;
        mon_en = 1'b1;
        for (int j = 0; j < 6; j++) q_tick.push_back(c0 + 4 + 4*j);
        for (int i = 0; i < 3; i++) begin
            q_r0.push_back(c0 + 5 + 8*i);
            q_f0.push_back(c0 + 9 + 8*i);
        end
        q_tick.push_back(c0 + 28); q_r0.push_back(c0 + 29);
        q_tick.push_back(c0 + 36); q_f0.push_back(c0 + 37);
        q_tick.push_back(c0 + 44); q_r0.push_back(c0 + 45);
        q_tick.push_back(c0 + 52); q_f0.push_back(c0 + 53);
        q_tick.push_back(c0 + 56); q_r0.push_back(c0 + 57);
        go_to(c0 + 25); we = 1'b1; data = 16'd8;
        go_to(c0 + 26); we = 1'b0;
        go_to(c0 + 43); we = 1'b1; data = 16'd4;
        go_to(c0 + 44); we = 1'b0;
        go_to(c0 + 58);
        sb_drained("run/reload pending events");

        // Asymmetric channel 1 (H=2, L=3) at reload 2
        do_reset();
        we = 1'b1; data = 16'd2;
        mon_ch1 = 1'b1;
        for (int j = 0; j < 13; j++) begin
            q_tick.push_back(c0 + 4 + 2*j);
            if (j % 2 == 0) q_r0.push_back(c0 + 5 + 2*j);
            else            q_f0.push_back(c0 + 5 + 2*j);
        end
        q_r1.push_back(c0 + 9);  q_f1.push_back(c0 + 13);
        q_r1.push_back(c0 + 19); q_f1.push_back(c0 + 23);
        q_r1.push_back(c0 + 29);
        go_to(c0 + 1); we = 1'b0;
        go_to(c0 + 30);
        sb_drained("asymmetric pending events");

        // Halt with channel 0 low, then one step
        mon_ch1 = 1'b0;
        do_reset();
        q_tick.push_back(c0 + 4); q_r0.push_back(c0 + 5);
        q_tick.push_back(c0 + 8); q_f0.push_back(c0 + 9);
        go_to(c0 + 10); mode = 2'b01;
        go_to(c0 + 12);
        snap = {tick, bus[8:5], bus[3:0]};
        mism = 0;
        for (int n = 13; n <= 112; n++) begin
            go_to(c0 + n);
            if ({tick, bus[8:5], bus[3:0]} != snap) mism++;
        end
        expect_eq("halt frozen mismatching cycles", mism, 0);
        mode = 2'b10;
        q_busy.push_back(c0 + 115);
        q_tick.push_back(c0 + 117); q_r0.push_back(c0 + 118);
        q_tick.push_back(c0 + 121); q_f0.push_back(c0 + 122);
        q_busy.push_back(c0 + 123);
        go_to(c0 + 114); step = 1'b1;
        go_to(c0 + 115); step = 1'b0;
        go_to(c0 + 117); step = 1'b1;
        go_to(c0 + 118); step = 1'b0;
        go_to(c0 + 140);
        sb_drained("step pending events");

        // Reset in the middle of a step while channel 0 is high
        step = 1'b1;
        q_busy.push_back(c0 + 141);
        q_tick.push_back(c0 + 143);
        q_r0.push_back(c0 + 144);
        go_to(c0 + 141); step = 1'b0;
        go_to(c0 + 145);
        sb_drained("pre-reset step pending events");
        expect_eq("ch0 high and busy before reset", {bus[0], busy}, 2'b11);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        expect_eq("async reset busy", busy, 0);
        expect_eq("async reset tick", tick, 0);
        expect_eq("async reset levels {ch1[3:0],ch0[3:0]}", {bus[8:5], bus[3:0]}, 8'h22);
        go_to(cyc + 2);
        rst_n   = 1'b1;
        c0      = cyc;
        mon_en  = 1'b1;
        mon_ch1 = 1'b1;
        t0      = tick_seen;
        go_to(c0 + 50);
        expect_eq("ticks in step mode without Step", tick_seen - t0, 0);
        expect_eq("busy idle after reset", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logisim_multi_clock_gen.md
# logisim_multi_clock_gen

Parametrised, multi-channel replacement for the Logisim tick generator and clock component pair in the FPGA top-level shell. One programmable tick divider drives N clock channels, each with its own high/low tick counts. Each channel emits a Logisim-style clock-tree bus. Adds run/halt/single-step control and runtime reload, so a CPU under test can be frozen, stepped one derived clock period at a time, or re-rated without resynthesis.

## Interface

Parameters:
- NrOfChannels, 2: number of derived clock channels (1..8).
- NrOfBits, 32: tick-divider width.
- ReloadValue, 3125000: tick period in FPGA cycles at reset.
- HighTicksVec, all 8'd1: packed NrOfChannels×8; per-channel high-phase length in ticks (1..255).
- LowTicksVec, all 8'd1: packed NrOfChannels×8; per-channel low-phase length in ticks (1..255).

Ports:
- FPGA_GlobalClock in 1: the single clock.
- FPGA_GlobalReset_n in 1: asynchronous, active-low reset.
- Mode in 2: 00 run, 01 halt, 10 step, 11 treated as run.
- Step in 1: single-step request, sampled in step mode.
- ReloadWe in 1: write strobe for ReloadData.
- ReloadData in NrOfBits: new tick period.
- ClockBus out 5×NrOfChannels: per channel k, bits [5k+4:5k].
  - bit0: clock.
  - bit1: inverted clock.
  - bit2: rising-edge strobe.
  - bit3: falling-edge strobe.
  - bit4: FPGA_GlobalClock passthrough.
- Tick out 1: one-cycle tick strobe.
- Busy out 1: high while a step is in progress.

## Operation

- **Tick divider**
  - Down-counter loaded from the reload register.
  - When the counter is 0 and ticking is enabled: Tick=1 for one cycle, and the counter reloads with reload−1.
  - Reload values 0 and 1 both produce a tick every cycle.
  - Ticking is enabled when Mode=run, or when Mode=step and Busy=1.
  - When disabled, the counter holds its value.
- **Reload register**
  - Resets to ReloadValue.
  - ReloadWe=1 captures ReloadData at the clock edge.
  - The running count is not disturbed; the new value applies from the next reload.
- **Channel k** has two states, LOW and HIGH, plus an 8-bit remaining-ticks counter.
  - On each tick the counter decrements.
  - When a tick arrives with counter=1, the channel toggles phase and loads the other phase length.
  - LOW→HIGH: load HighTicks[k] and pulse bit2.
  - HIGH→LOW: load LowTicks[k] and pulse bit3.
  - Derived period = HighTicks[k]+LowTicks[k] ticks.
- **Step mode**
  - Step=1 with Busy=0: Busy←1 on the next edge.
  - Busy clears in the cycle after channel 0's falling-edge strobe, i.e. exactly one full channel-0 period.
  - Steps while Busy=1 are ignored.
  - The other channels advance by the same number of ticks.
- **Mode changes**
  - Leaving step mode mid-step clears Busy immediately.
  - Halt freezes all counters, phases and clock levels.
  - Entering run resumes from the frozen state, with no phase reset.

## Timing

- **Reset values:**
  - ClockBus bits 0 and 2–3 are 0 and bit1 is 1 for every channel; bit4 follows FPGA_GlobalClock combinationally.
  - Tick=0, Busy=0.
  - Divider count = ReloadValue−1; reload register = ReloadValue.
  - Every channel is in LOW with counter=LowTicks[k].
- All outputs except bit4 are registered.
- The clock level changes in the cycle after the causing Tick.
- Edge strobes are high in the same cycle as the new clock level, for exactly one cycle.
- Tick-to-clock latency is 1 cycle.
- A simultaneous ReloadWe and divider reload uses the old value for that reload.
- Asserting reset mid-step or mid-period returns every output to its reset value asynchronously, and Busy drops at once.
- All-channel phase toggles coincide when they share the same tick.

## Structure

- Package logisim_clk_pkg holds:
  - mode encodings MODE_RUN, MODE_HALT, MODE_STEP;
  - clock-bus bit indices CB_CLK, CB_CLK_N, CB_RISE, CB_FALL, CB_GCLK;
  - the CB_WIDTH=5 constant.
- Sub-module logisim_clock_channel holds one channel's phase state, counter and bus register. It is instantiated NrOfChannels times in a generate loop.
- The divider, reload register and step FSM (IDLE / STEPPING) live in the top module.

## Test plan

- **Reset:** hold FPGA_GlobalReset_n=0 → every ClockBus bit0=0, bit1=1, Tick=0, Busy=0; release → first Tick after ReloadValue cycles.
- **Run:** ReloadValue=4, H=L=1 → Tick every 4 cycles; channel 0 toggles every 4 cycles (period 8); rise/fall strobes are one cycle wide and coincide with the level change.
- **Asymmetric channel:** channel 1 with H=2, L=3, reload=2 → high for 4 cycles, low for 6, period 10.
- **Runtime reload:** write ReloadData=8 mid-count with reload=4 → the current interval still ends at 4; subsequent Ticks come 8 apart.
- **Halt and step:** halt mid-period → outputs frozen for 100 cycles. Then Mode=step with one Step pulse (reload=4, H=L=1) → Busy high, exactly one rise and one fall on channel 0, Busy low one cycle after the fall. A second Step during Busy → no extra edges.
- **Reset mid-step:** assert reset while Busy=1 → Busy=0 and all clocks low immediately; after release with Mode=step and no Step → no Ticks.
